// File: rtl/enc_ctrl_pkg.sv
// enc_ctrl_pkg: shared state type, acceleration constants and value clamp for the encoder menu
package enc_ctrl_pkg;
    typedef enum logic [1:0] {BROWSE, EDIT, COMMIT} state_t;
    localparam int ACCEL_WIN  = 50000;
    localparam int ACCEL_STEP = 4;
    function automatic int clamp(input int v, input int lo, input int hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction
endpackage

// File: rtl/enc_delta.sv
// enc_delta: registers the previous encoder position and yields a signed per-cycle delta
// ENC_MENU_ACCEL_EN adds a saturating window counter that flags closely spaced detents
module enc_delta
    import enc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [3:0]        enc_counter,
    output logic signed [3:0] delta,
    output logic              fast
);
    logic [3:0] enc_prev;
    logic       primed;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            enc_prev <= '0;
            primed   <= 1'b0;
        end else begin
            enc_prev <= enc_counter;
            primed   <= 1'b1;
        end
    // the first cycle out of reset only learns the encoder position
    assign delta = primed ? signed'(enc_counter - enc_prev) : 4'sd0;
`ifdef ENC_MENU_ACCEL_EN
    logic [15:0] win_cnt;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            win_cnt <= '1;
        else if (delta != 4'sd0)
            win_cnt <= '0;
        else if (win_cnt != '1)
            win_cnt <= win_cnt + 16'd1;
    assign fast = (delta != 4'sd0) && (int'(win_cnt) < ACCEL_WIN);
`else
    assign fast = 1'b0;
`endif
endmodule

// File: rtl/enc_menu_ctrl.sv
// enc_menu_ctrl: encoder-driven parameter menu with browse/edit/commit states and a valid/ready commit port
// ENC_MENU_ACCEL_EN enables x4 edit steps for fast rotation (handled in enc_delta)
module enc_menu_ctrl
    import enc_ctrl_pkg::*;
#(
    parameter  int NUM_PARAMS   = 4,
    parameter  int VAL_W        = 8,
    parameter  int VAL_MAX      = 255,
    parameter  int DEFAULT_VAL  = 0,
    parameter  int DEBOUNCE_CNT = 8,
    parameter  int LONG_CNT     = 2000,
    localparam int IDX_W        = $clog2(NUM_PARAMS)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [3:0]                  enc_counter,
    input  logic                        pb_n,
    input  logic [11:0]                 pb_cnt,
    output logic [IDX_W-1:0]            sel_idx,
    output logic                        edit_mode,
    output logic [NUM_PARAMS*VAL_W-1:0] param_flat,
    output logic                        cfg_valid,
    input  logic                        cfg_ready
);
    logic signed [3:0] delta;
    logic              fast;
    enc_delta u_delta (
        .clk         (clk),
        .rstn        (rstn),
        .enc_counter (enc_counter),
        .delta       (delta),
        .fast        (fast)
    );
    logic        pb_prev, long_fired;
    logic [11:0] last_cnt;
    logic        short_ev, long_ev;
    assign long_ev  = !pb_n && pb_cnt == 12'(LONG_CNT) && !long_fired;
    assign short_ev = !pb_prev && pb_n && !long_fired &&
                      last_cnt >= 12'(DEBOUNCE_CNT) && last_cnt < 12'(LONG_CNT);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            pb_prev    <= 1'b1;
            last_cnt   <= '0;
            long_fired <= 1'b0;
        end else begin
            pb_prev    <= pb_n;
            last_cnt   <= pb_n ? last_cnt : pb_cnt;
            long_fired <= pb_n ? 1'b0 : (long_fired || long_ev);
        end
    state_t           state;
    logic [VAL_W-1:0] slot [NUM_PARAMS];
    logic [VAL_W-1:0] entry_val;
    logic [IDX_W-1:0] nxt_sel;
    logic [VAL_W-1:0] nxt_val;
    int               step;
    assign step    = fast ? ACCEL_STEP : 1;
    // the bias keeps the dividend non-negative so both directions wrap
    assign nxt_sel = IDX_W'((int'(sel_idx) + int'(delta) + 8 * NUM_PARAMS) % NUM_PARAMS);
    assign nxt_val = VAL_W'(clamp(int'(slot[sel_idx]) + int'(delta) * step, 0, VAL_MAX));
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state     <= BROWSE;
            sel_idx   <= '0;
            edit_mode <= 1'b0;
            cfg_valid <= 1'b0;
            entry_val <= VAL_W'(DEFAULT_VAL);
            for (int i = 0; i < NUM_PARAMS; i++)
                slot[i] <= VAL_W'(DEFAULT_VAL);
        end else begin
            case (state)
                BROWSE: begin
                    sel_idx <= nxt_sel;
                    if (long_ev) begin
                        state     <= COMMIT;
                        cfg_valid <= 1'b1;
                    end else if (short_ev) begin
                        state     <= EDIT;
                        edit_mode <= 1'b1;
                        entry_val <= slot[nxt_sel];
                    end
                end
                EDIT: begin
                    slot[sel_idx] <= long_ev ? entry_val : nxt_val;
                    if (long_ev || short_ev) begin
                        state     <= BROWSE;
                        edit_mode <= 1'b0;
                    end
                end
                COMMIT: if (cfg_ready) begin
                    state     <= BROWSE;
                    cfg_valid <= 1'b0;
                end
                default: state <= BROWSE;
            endcase
        end
    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
        assign param_flat[g*VAL_W +: VAL_W] = slot[g];
    end
endmodule

// File: tb/tb_enc_menu_ctrl.sv
// tb_enc_menu_ctrl: directed and randomized checks of enc_menu_ctrl against a transaction-level model
module tb_enc_menu_ctrl;
    localparam int N = 4, W = 8, VMAX = 255, DEB = 8, LONG = 2000;
    logic           clk = 1'b0, rstn = 1'b0;
    logic [3:0]     enc_counter = 4'd0;
    logic           pb_n = 1'b1;
    logic [11:0]    pb_cnt = 12'd0;
    logic [1:0]     sel_idx;
    logic           edit_mode, cfg_valid;
    logic           cfg_ready = 1'b0;
    logic [N*W-1:0] param_flat;
    int checks = 0, failures = 0;
    int m_sel, m_mode, m_entry;
    int m_val [N];

    always #5 clk = ~clk;

    enc_menu_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .enc_counter (enc_counter),
        .pb_n        (pb_n),
        .pb_cnt      (pb_cnt),
        .sel_idx     (sel_idx),
        .edit_mode   (edit_mode),
        .param_flat  (param_flat),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready)
    );

    function automatic logic [N*W-1:0] exp_flat();
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = W'(m_val[i]);
        return f;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_mode = 0; m_entry = 0;
        for (int i = 0; i < N; i++) m_val[i] = 0;
    endtask

    task automatic do_reset(input logic [3:0] e);
        @(negedge clk);
        rstn = 1'b0; pb_n = 1'b1; pb_cnt = 12'd0; cfg_ready = 1'b0; enc_counter = e;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic rotate(input int d);
        int v;
        @(negedge clk);
        enc_counter = enc_counter + 4'(d);
        @(negedge clk);
        if (m_mode == 0) m_sel = (m_sel + d + 8 * N) % N;
        else if (m_mode == 1) begin
            v = m_val[m_sel] + d;
            m_val[m_sel] = v < 0 ? 0 : (v > VMAX ? VMAX : v);
        end
    endtask

    task automatic press(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            pb_n = 1'b0; pb_cnt = 12'(i);
        end
        @(negedge clk);
        pb_n = 1'b1; pb_cnt = 12'd0;
        @(negedge clk);
        if (n >= LONG) begin
            if (m_mode == 0) m_mode = 2;
            else if (m_mode == 1) begin m_val[m_sel] = m_entry; m_mode = 0; end
        end else if (n >= DEB) begin
            if (m_mode == 0) begin m_mode = 1; m_entry = m_val[m_sel]; end
            else if (m_mode == 1) m_mode = 0;
        end
    endtask

    task automatic ready_pulse();
        @(negedge clk);
        cfg_ready = 1'b1;
        @(negedge clk);
        cfg_ready = 1'b0;
        if (m_mode == 2) m_mode = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enc_counter = 4'd6;
        model_reset();
        #12;
        checks++; if (sel_idx !== 2'd0 || edit_mode !== 1'b0 || cfg_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got sel=%0d edit=%0b valid=%0b exp 0/0/0", sel_idx, edit_mode, cfg_valid);
        end
        checks++; if (param_flat !== '0) begin
            failures++; $display("FAIL reset_flat got=%h exp=0", param_flat);
        end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (sel_idx !== 2'd0) begin
            failures++; $display("FAIL prime_no_delta got sel=%0d exp=0", sel_idx);
        end
    endtask

    task automatic test_browse();
        int seq [5] = '{1, 1, -1, -1, -1};
        do_reset(4'd8);
        foreach (seq[k]) begin
            rotate(seq[k]);
            checks++; if (sel_idx !== 2'(m_sel)) begin
                failures++; $display("FAIL browse_step%0d got sel=%0d exp=%0d", k, sel_idx, m_sel);
            end
        end
        rotate(7); rotate(1);
        checks++; if (enc_counter !== 4'hF || sel_idx !== 2'(m_sel)) begin
            failures++; $display("FAIL browse_to_F got sel=%0d exp=%0d", sel_idx, m_sel);
        end
        rotate(1);
        checks++; if (sel_idx !== 2'(m_sel) || m_sel != 0) begin
            failures++; $display("FAIL browse_enc_wrap got sel=%0d exp=%0d", sel_idx, m_sel);
        end
    endtask

    task automatic test_edit();
        press(20);
        checks++; if (edit_mode !== 1'b1) begin
            failures++; $display("FAIL short_to_edit got edit=%0b exp=1", edit_mode);
        end
        for (int i = 0; i < 3; i++) rotate(1);
        checks++; if (param_flat !== exp_flat() || m_val[0] != 3) begin
            failures++; $display("FAIL edit_plus3 got=%h exp=%h", param_flat, exp_flat());
        end
        rotate(-5);
        checks++; if (param_flat !== exp_flat() || m_val[0] != 0) begin
            failures++; $display("FAIL edit_sat_low got=%h exp=%h", param_flat, exp_flat());
        end
    endtask

    task automatic test_revert();
        for (int i = 0; i < 35; i++) rotate(7);
        rotate(5);
        checks++; if (param_flat[7:0] !== 8'd250) begin
            failures++; $display("FAIL edit_250 got=%0d exp=250", param_flat[7:0]);
        end
        rotate(7); rotate(3);
        checks++; if (param_flat[7:0] !== 8'd255) begin
            failures++; $display("FAIL edit_sat_high got=%0d exp=255", param_flat[7:0]);
        end
        press(LONG + 3);
        checks++; if (param_flat !== exp_flat() || edit_mode !== 1'b0) begin
            failures++; $display("FAIL long_revert got=%h edit=%0b exp=%h edit=0", param_flat, edit_mode, exp_flat());
        end
    endtask

    task automatic test_commit();
        logic [N*W-1:0] snap;
        rotate(2);
        press(LONG + 1);
        checks++; if (cfg_valid !== 1'b1 || edit_mode !== 1'b0) begin
            failures++; $display("FAIL commit_enter got valid=%0b edit=%0b exp 1/0", cfg_valid, edit_mode);
        end
        snap = exp_flat();
        for (int i = 0; i < 5; i++) rotate(int'($urandom_range(1, 7)));
        press(20);
        checks++; if (cfg_valid !== 1'b1 || sel_idx !== 2'(m_sel) || param_flat !== snap || edit_mode !== 1'b0) begin
            failures++; $display("FAIL commit_hold got valid=%0b sel=%0d exp valid=1 sel=%0d", cfg_valid, sel_idx, m_sel);
        end
        ready_pulse();
        checks++; if (cfg_valid !== 1'b0 || edit_mode !== 1'b0) begin
            failures++; $display("FAIL commit_release got valid=%0b exp=0", cfg_valid);
        end
        rotate(1);
        checks++; if (sel_idx !== 2'(m_sel)) begin
            failures++; $display("FAIL browse_after_commit got sel=%0d exp=%0d", sel_idx, m_sel);
        end
    endtask

    task automatic test_debounce();
        int lens [6] = '{5, 7, 8, 1999, 1999, 2000};
        foreach (lens[k]) begin
            press(lens[k]);
            checks++; if (edit_mode !== (m_mode == 1) || cfg_valid !== (m_mode == 2) || param_flat !== exp_flat()) begin
                failures++; $display("FAIL press_len%0d got edit=%0b valid=%0b exp mode=%0d", lens[k], edit_mode, cfg_valid, m_mode);
            end
        end
    endtask

    task automatic test_reset_commit();
        if (m_mode != 2) begin
            if (m_mode == 1) press(20);
            press(LONG);
        end
        checks++; if (cfg_valid !== 1'b1) begin
            failures++; $display("FAIL pre_reset_commit got valid=%0b exp=1", cfg_valid);
        end
        @(negedge clk); rstn = 1'b0;
        #1;
        checks++; if (cfg_valid !== 1'b0 || sel_idx !== 2'd0 || edit_mode !== 1'b0) begin
            failures++; $display("FAIL async_reset_commit got valid=%0b sel=%0d exp 0/0", cfg_valid, sel_idx);
        end
        model_reset();
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 200; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5) rotate(int'($urandom_range(0, 15)) - 8);
            else if (r <= 8) press($urandom_range(0, 49) == 0 ? int'($urandom_range(LONG, LONG + 10)) : int'($urandom_range(1, 40)));
            else ready_pulse();
            checks++; if (sel_idx !== 2'(m_sel) || edit_mode !== (m_mode == 1) || cfg_valid !== (m_mode == 2) || param_flat !== exp_flat()) begin
                failures++; $display("FAIL random_it%0d got sel=%0d edit=%0b valid=%0b flat=%h exp sel=%0d mode=%0d flat=%h",
                    it, sel_idx, edit_mode, cfg_valid, param_flat, m_sel, m_mode, exp_flat());
            end
        end
    endtask

    initial begin
        test_reset();
        test_browse();
        test_edit();
        test_revert();
        test_commit();
        test_debounce();
        test_reset_commit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
